// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse transmit front-end blocks.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SEP   = 2'd2
    } arb_state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_NUL   = 8'h00;

    // Smallest width able to index v distinct values; never less than 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after ptr, with wrap.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic               found,
    output logic [IDW-1:0]     idx
);

    int cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/morse_tx_arb.sv
// Message-atomic round-robin arbiter feeding one morse_tx from NUM_REQ byte sources.
module morse_tx_arb
    import morse_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MAX_LEN = 32,
    parameter int SEP_EN  = 1,
    parameter int IDW     = 2
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_write_en,
    output logic [7:0]             tx_ascii,
    input  logic                   tx_full,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy,
    output logic                   trunc_err
);

    localparam int CNT_W = clog2(MAX_LEN + 1);

    arb_state_t           state, state_nxt;
    logic [IDW-1:0]       rr_ptr, rr_ptr_nxt, grant_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt, cnt_inc;
    logic                 pick_found;
    logic [IDW-1:0]       pick_idx;
    logic [NUM_REQ-1:0]   g_sel;
    logic                 g_valid, g_last, xfer, rel;
    logic [7:0]           g_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        g_sel   = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDW'(i)) begin
                g_sel[i] = 1'b1;
                g_valid  = req_valid[i];
                g_last   = req_last[i];
                g_data   = req_data[8*i +: 8];
            end
        end
    end

    assign cnt_inc = cnt + 1'b1;
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= IDW'(NUM_REQ - 1);
            cnt      <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            cnt      <= cnt_nxt;
            grant_id <= grant_nxt;
        end
    end

    // Bytes pass straight through to morse_tx in the cycle they are accepted,
    // so a stream sustains one byte per clock while tx_full stays low.
    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        grant_nxt   = grant_id;
        cnt_nxt     = cnt;
        req_ready   = '0;
        tx_write_en = 1'b0;
        tx_ascii    = '0;
        trunc_err   = 1'b0;
        xfer        = 1'b0;
        rel         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_nxt = pick_idx;
                    cnt_nxt   = '0;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                req_ready = g_sel & {NUM_REQ{~tx_full}};
                xfer      = g_valid && !tx_full;
                if (xfer) begin
                    rel = g_last;
                    // NUL bytes are swallowed: consumed but neither sent nor counted.
                    if (g_data != ASCII_NUL) begin
                        tx_write_en = 1'b1;
                        tx_ascii    = g_data;
                        cnt_nxt     = cnt_inc;
                        if (!g_last && cnt_inc == CNT_W'(MAX_LEN)) begin
                            rel       = 1'b1;
                            trunc_err = 1'b1;
                        end
                    end
                end
                if (rel) begin
                    rr_ptr_nxt = grant_id;
                    state_nxt  = (SEP_EN != 0) ? ST_SEP : ST_IDLE;
                end
            end
            ST_SEP: begin
                if (!tx_full) begin
                    tx_write_en = 1'b1;
                    tx_ascii    = ASCII_SPACE;
                    state_nxt   = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_morse_tx_arb.sv
// Directed scoreboard bench for morse_tx_arb with per-requester byte sources.
module tb_morse_tx_arb;

    localparam int NUM_REQ = 4;
    localparam int MAX_LEN = 3;
    localparam int SEP_EN  = 1;
    localparam int IDW     = 2;

    logic                 clk = 1'b0;
    logic                 arst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_write_en;
    logic [7:0]           tx_ascii;
    logic                 tx_full;
    logic [IDW-1:0]       grant_id;
    logic                 busy;
    logic                 trunc_err;

    int checks    = 0;
    int errors    = 0;
    int wr_cnt    = 0;
    int trunc_cnt = 0;

    logic [7:0] exp_q[$];
    logic [8:0] q0[$], q1[$], q2[$], q3[$];
    logic [NUM_REQ-1:0] acc;
    logic [7:0] mon_e;
    logic prev_sep = 1'b0;

    always #5 clk = ~clk;

    morse_tx_arb #(
        .NUM_REQ (NUM_REQ),
        .MAX_LEN (MAX_LEN),
        .SEP_EN  (SEP_EN),
        .IDW     (IDW)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_write_en (tx_write_en),
        .tx_ascii    (tx_ascii),
        .tx_full     (tx_full),
        .grant_id    (grant_id),
        .busy        (busy),
        .trunc_err   (trunc_err)
    );

    task automatic push_src(input int id, input logic [8:0] v);
        case (id)
            0: q0.push_back(v);
            1: q1.push_back(v);
            2: q2.push_back(v);
            default: q3.push_back(v);
        endcase
    endtask

    task automatic pop_src(input int id);
        case (id)
            0: if (q0.size() > 0) void'(q0.pop_front());
            1: if (q1.size() > 0) void'(q1.pop_front());
            2: if (q2.size() > 0) void'(q2.pop_front());
            default: if (q3.size() > 0) void'(q3.pop_front());
        endcase
    endtask

    function automatic logic [9:0] head(input int id);
        logic [9:0] h;
        h = '0;
        case (id)
            0: if (q0.size() > 0) h = {1'b1, q0[0]};
            1: if (q1.size() > 0) h = {1'b1, q1[0]};
            2: if (q2.size() > 0) h = {1'b1, q2[0]};
            default: if (q3.size() > 0) h = {1'b1, q3[0]};
        endcase
        return h;
    endfunction

    function automatic bit src_empty();
        return (q0.size() == 0) && (q1.size() == 0) && (q2.size() == 0) && (q3.size() == 0);
    endfunction

    task automatic send_byte(input int id, input logic [7:0] d, input bit last);
        push_src(id, {last, d});
    endtask

    task automatic send_str(input int id, input string s, input bit last);
        for (int i = 0; i < s.len(); i++)
            push_src(id, {(last && i == s.len() - 1), s[i]});
    endtask

    task automatic expect_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic wait_drain(input int budget, input string tag, input bit need_idle);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && src_empty() && (!need_idle || !busy)) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        assert (done === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=timeout(pending %0d) required=drained", tag, exp_q.size());
        end
    endtask

    task automatic wait_writes(input int target, input int budget, input string tag);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            #1;
            if (wr_cnt >= target) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        assert (done === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%0d writes required=%0d", tag, wr_cnt, target);
        end
    endtask

    // Source model: a byte leaves its queue only when valid && ready held at the edge.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) if (acc[i]) pop_src(i);
            for (int i = 0; i < NUM_REQ; i++) begin
                logic [9:0] h;
                h = head(i);
                req_valid[i]        = h[9];
                req_last[i]         = h[8];
                req_data[8*i +: 8]  = h[7:0];
            end
        end
    end

    // Output monitor: stream order against the scoreboard plus protocol invariants.
    initial begin
        forever begin
            @(negedge clk);
            if (arst_n) begin
                if (tx_write_en) begin
                    wr_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $error("FAIL stream_extra observed=%02h required=none", tx_ascii);
                    end else begin
                        mon_e = exp_q.pop_front();
                        assert (tx_ascii === mon_e) else begin
                            errors++;
                            $error("FAIL stream_byte observed=%02h required=%02h", tx_ascii, mon_e);
                        end
                    end
                end else begin
                    checks++;
                    assert (tx_ascii === 8'h00) else begin
                        errors++;
                        $error("FAIL ascii_idle observed=%02h required=00", tx_ascii);
                    end
                end
                checks++;
                assert ($onehot0(req_ready) === 1'b1) else begin
                    errors++;
                    $error("FAIL ready_onehot observed=%b required=onehot0", req_ready);
                end
                if (tx_full) begin
                    checks++;
                    assert ({tx_write_en, req_ready} === 5'b0) else begin
                        errors++;
                        $error("FAIL full_stall observed=%b required=00000", {tx_write_en, req_ready});
                    end
                end
                if (prev_sep) begin
                    checks++;
                    assert (busy === 1'b0) else begin
                        errors++;
                        $error("FAIL busy_after_sep observed=%b required=0", busy);
                    end
                end
                prev_sep = tx_write_en && (tx_ascii == 8'h20) && (req_ready == '0);
                if (trunc_err) trunc_cnt++;
            end else begin
                prev_sep = 1'b0;
            end
        end
    end

    initial begin
        int base;
        int tc0;
        tx_full = 1'b0;
        arst_n  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        assert ({req_ready, tx_write_en, tx_ascii, busy, trunc_err, grant_id} === '0) else begin
            errors++;
            $error("FAIL reset_outputs observed=%h required=0",
                   {req_ready, tx_write_en, tx_ascii, busy, trunc_err, grant_id});
        end
        arst_n = 1'b1;

        // Single source with separator.
        send_str(1, "SOS", 1'b1);
        expect_str("SOS ");
        wait_drain(60, "sos_drain", 1'b1);
        checks++;
        assert (grant_id === 2'd1) else begin
            errors++;
            $error("FAIL sos_grant observed=%0d required=1", grant_id);
        end

        // Contention from reset: 0 wins first, then the pointer alternates 2,0,2.
        @(negedge clk);
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        send_str(0, "A", 1'b1);
        send_str(0, "C", 1'b1);
        send_str(2, "B", 1'b1);
        send_str(2, "D", 1'b1);
        expect_str("A B C D ");
        wait_drain(80, "contend_drain", 1'b1);
        checks++;
        assert (grant_id === 2'd2) else begin
            errors++;
            $error("FAIL contend_grant observed=%0d required=2", grant_id);
        end

        // Backpressure mid-message and during the separator.
        base = wr_cnt;
        send_str(3, "HI!", 1'b1);
        expect_str("HI! ");
        wait_writes(base + 1, 40, "bp_first");
        @(posedge clk);
        #1 tx_full = 1'b1;
        repeat (5) @(posedge clk);
        #1 tx_full = 1'b0;
        wait_writes(base + 3, 40, "bp_body");
        @(posedge clk);
        #1 tx_full = 1'b1;
        @(negedge clk);
        checks++;
        assert ({busy, tx_write_en} === 2'b10) else begin
            errors++;
            $error("FAIL sep_stall observed=%b required=10", {busy, tx_write_en});
        end
        repeat (4) @(posedge clk);
        #1 tx_full = 1'b0;
        wait_drain(60, "bp_drain", 1'b1);
        checks++;
        assert (grant_id === 2'd3) else begin
            errors++;
            $error("FAIL bp_grant observed=%0d required=3", grant_id);
        end

        // Truncation at MAX_LEN=3: ABC forced out, DE re-arbitrated as a new message.
        tc0 = trunc_cnt;
        send_str(3, "ABCDE", 1'b1);
        expect_str("ABC DE ");
        wait_drain(80, "trunc_drain", 1'b1);
        checks++;
        assert (trunc_cnt - tc0 === 1) else begin
            errors++;
            $error("FAIL trunc_pulses observed=%0d required=1", trunc_cnt - tc0);
        end

        // NUL bytes are dropped, including one carrying last.
        tc0 = trunc_cnt;
        send_byte(1, 8'h00, 1'b0);
        send_byte(1, 8'h45, 1'b0);
        send_byte(1, 8'h00, 1'b1);
        expect_str("E ");
        wait_drain(60, "nul_drain", 1'b1);
        checks++;
        assert (trunc_cnt - tc0 === 0) else begin
            errors++;
            $error("FAIL nul_trunc observed=%0d required=0", trunc_cnt - tc0);
        end

        // Grantee stalls mid-message, then reset abandons it.
        send_byte(2, 8'h58, 1'b0);
        expect_str("X");
        wait_drain(40, "hold_drain", 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        assert ({busy, grant_id} === 3'b110) else begin
            errors++;
            $error("FAIL hold_grant observed=%b required=110", {busy, grant_id});
        end
        @(negedge clk);
        #2 arst_n = 1'b0;
        #1;
        checks++;
        assert ({req_ready, tx_write_en, tx_ascii, busy, trunc_err, grant_id} === '0) else begin
            errors++;
            $error("FAIL midreset_outputs observed=%h required=0",
                   {req_ready, tx_write_en, tx_ascii, busy, trunc_err, grant_id});
        end
        send_str(0, "K", 1'b1);
        send_str(2, "Z", 1'b1);
        expect_str("K Z ");
        @(negedge clk);
        arst_n = 1'b1;
        wait_drain(60, "post_reset_drain", 1'b1);
        checks++;
        assert (grant_id === 2'd2) else begin
            errors++;
            $error("FAIL post_reset_grant observed=%0d required=2", grant_id);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
